icache: RTL and testbench

Direct-mapped, read-only instruction cache between the CPU fetch stage and the 512-bit-line instruction ROM. It serves 32-bit instruction words to fetch on a hit. On a miss, it runs a one-line fill over the ROM's chip_select/addr_valid/data_ready handshake, installs the 64-byte line, and then serves the word. Supports a full-cache flush and a saturating miss counter for performance measurement.

---
 rtl/icache.sv | 133 +++++++++++++
 tb/tb_icache.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache. Serves 32-bit words to fetch on a hit
// and fills one 512-bit line from the instruction ROM on a miss.
module icache #(
    parameter int LINES  = 4,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_valid,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic [31:0]       fetch_data,
    input  logic              flush,
    output logic              mem_cs,
    output logic              mem_addr_valid,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_data_ready,
    input  logic [511:0]      mem_data,
    output logic [15:0]       miss_count
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - 6 - IDX_W;

    typedef enum logic {
        IDLE,
        FILL
    } state_e;

    state_e              state_q, state_d;
    logic [LINES-1:0]    valid_q, valid_d;
    logic [15:0]         miss_count_q, miss_count_d;
    logic                mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;

    logic [TAG_W-1:0]    tag_mem_q  [LINES];
    logic [511:0]        data_mem_q [LINES];

    logic [3:0]          f_word;
    logic [IDX_W-1:0]    f_idx;
    logic [TAG_W-1:0]    f_tag;
    logic [IDX_W-1:0]    fill_idx;
    logic [TAG_W-1:0]    fill_tag;
    logic [511:0]        sel_line;
    logic                hit;
    logic                line_we;

    assign f_word   = fetch_addr[5:2];
    assign f_idx    = fetch_addr[6 +: IDX_W];
    assign f_tag    = fetch_addr[ADDR_W-1 -: TAG_W];
    // The request address register doubles as the fill address while in FILL.
    assign fill_idx = mem_addr_q[6 +: IDX_W];
    assign fill_tag = mem_addr_q[ADDR_W-1 -: TAG_W];
    assign sel_line = data_mem_q[f_idx];

    // NOTE: every signal gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        miss_count_d = miss_count_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        hit          = 1'b0;
        line_we      = 1'b0;

        case (state_q)
            IDLE: begin
                hit = fetch_valid & valid_q[f_idx] & (tag_mem_q[f_idx] == f_tag) & ~flush;
                if (fetch_valid && !hit && !flush) begin
                    state_d    = FILL;
                    mem_req_d  = 1'b1;
                    mem_addr_d = {fetch_addr[ADDR_W-1:6], 6'b0};
                    if (miss_count_q != 16'hFFFF) begin
                        miss_count_d = miss_count_q + 16'd1;
                    end
                end
            end
            FILL: begin
                if (mem_data_ready) begin
                    line_we           = 1'b1;
                    valid_d[fill_idx] = 1'b1;
                    state_d           = IDLE;
                    mem_req_d         = 1'b0;
                    mem_addr_d        = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Flush overrides any valid bit set by a completing fill.
        if (flush) begin
            valid_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            miss_count_q <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            miss_count_q <= miss_count_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
        end
    end

    // NOTE: tag and data arrays are deliberately left unreset; the valid bits
    // alone decide whether their contents mean anything.
    always_ff @(posedge clk) begin
        if (line_we) begin
            data_mem_q[fill_idx] <= mem_data;
            tag_mem_q[fill_idx]  <= fill_tag;
        end
    end

    assign fetch_ready    = hit;
    assign fetch_data     = hit ? sel_line[{f_word, 5'b0} +: 32] : 32'h0;
    assign mem_cs         = mem_req_q;
    assign mem_addr_valid = mem_req_q;
    assign mem_addr       = mem_addr_q;
    assign miss_count     = miss_count_q;

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: a combinational ROM model, a scoreboard of expected
// fetch words and latencies, and immediate-assertion checks.
module tb_icache;

    localparam int ADDR_W = 15;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              fetch_valid;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ready;
    logic [31:0]       fetch_data;
    logic              flush;
    logic              mem_cs;
    logic              mem_addr_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_data_ready;
    logic [511:0]      mem_data;
    logic [15:0]       miss_count;

    logic              rom_rdy;
    int                total = 0;
    int                bad   = 0;
    int                exp_miss = 0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       word;
        int                lat;
    } exp_t;

    exp_t sb[$];

    icache #(.LINES(4), .ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_valid    (fetch_valid),
        .fetch_addr     (fetch_addr),
        .fetch_ready    (fetch_ready),
        .fetch_data     (fetch_data),
        .flush          (flush),
        .mem_cs         (mem_cs),
        .mem_addr_valid (mem_addr_valid),
        .mem_addr       (mem_addr),
        .mem_data_ready (mem_data_ready),
        .mem_data       (mem_data),
        .miss_count     (miss_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_byte(input int unsigned a);
        return 8'((a * 37) + ((a >> 6) * 11) + 8'h5A);
    endfunction

    function automatic logic [31:0] exp_word(input logic [ADDR_W-1:0] a);
        int unsigned b;
        b = int'(a);
        return {rom_byte(b + 3), rom_byte(b + 2), rom_byte(b + 1), rom_byte(b)};
    endfunction

    always_comb begin
        mem_data = '0;
        for (int k = 0; k < 64; k++) begin
            mem_data[8*k +: 8] = rom_byte(int'(mem_addr) + k);
        end
    end

    assign mem_data_ready = rom_rdy;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts just after a falling edge; returns just after the falling edge that
    // follows the cycle in which fetch_ready was seen.
    task automatic do_fetch(input logic [ADDR_W-1:0] a, input int exp_lat,
                            input int stall, input int flush_at, input string tag);
        exp_t e;
        int   lat;
        bit   got;
        sb.push_back('{a, exp_word(a), exp_lat});
        fetch_valid = 1'b1;
        fetch_addr  = a;
        lat = 0;
        got = 1'b0;
        while (lat < 60) begin
            rom_rdy = !(lat >= 1 && lat <= stall);
            flush   = (lat == flush_at);
            #1;
            if (fetch_ready) begin
                got = 1'b1;
                break;
            end
            if (lat >= 1 && lat <= stall + 1 && flush_at < 0) begin
                check({tag, " req_valid"}, 64'(mem_addr_valid), 64'd1);
                check({tag, " req_addr"}, 64'(mem_addr), 64'({a[ADDR_W-1:6], 6'b0}));
            end
            @(negedge clk);
            lat++;
        end
        flush   = 1'b0;
        rom_rdy = 1'b1;
        check({tag, " ready_seen"}, 64'(got), 64'd1);
        e = sb.pop_front();
        if (got) begin
            check({tag, " data"}, 64'(fetch_data), 64'(e.word));
            check({tag, " latency"}, 64'(lat), 64'(e.lat));
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n       = 1'b0;
        fetch_valid = 1'b0;
        fetch_addr  = '0;
        flush       = 1'b0;
        rom_rdy     = 1'b1;
        #12;
        check("rst fetch_ready", 64'(fetch_ready), 64'd0);
        check("rst fetch_data", 64'(fetch_data), 64'd0);
        check("rst mem_cs", 64'(mem_cs), 64'd0);
        check("rst mem_addr_valid", 64'(mem_addr_valid), 64'd0);
        check("rst mem_addr", 64'(mem_addr), 64'd0);
        check("rst miss_count", 64'(miss_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // First miss, then same-line hits back to back.
        do_fetch(15'h0000, 2, 0, -1, "miss0");
        exp_miss++;
        check("miss_count after first", 64'(miss_count), 64'(exp_miss));
        do_fetch(15'h0004, 0, 0, -1, "hit w1");
        do_fetch(15'h0008, 0, 0, -1, "hit w2");
        do_fetch(15'h003C, 0, 0, -1, "hit w15");
        check("miss_count after hits", 64'(miss_count), 64'(exp_miss));

        // Conflict on idx 0 with a different tag.
        do_fetch(15'h0100, 2, 0, -1, "conflict");
        do_fetch(15'h0000, 2, 0, -1, "refill0");
        exp_miss += 2;
        check("miss_count conflicts", 64'(miss_count), 64'(exp_miss));

        // ROM stalls five cycles.
        do_fetch(15'h0040, 7, 5, -1, "stall");
        exp_miss++;
        check("miss_count stall", 64'(miss_count), 64'(exp_miss));
        do_fetch(15'h0044, 0, 0, -1, "stall hit");

        // Warm all four lines, flush, then every line misses again.
        do_fetch(15'h0080, 2, 0, -1, "warm2");
        do_fetch(15'h00C0, 2, 0, -1, "warm3");
        exp_miss += 2;
        do_fetch(15'h0010, 0, 0, -1, "warm hit0");
        do_fetch(15'h0050, 0, 0, -1, "warm hit1");
        do_fetch(15'h0090, 0, 0, -1, "warm hit2");
        do_fetch(15'h00D0, 0, 0, -1, "warm hit3");
        fetch_addr = 15'h0010;
        flush      = 1'b1;
        #1;
        check("flush hit suppressed", 64'(fetch_ready), 64'd0);
        check("flush data zero", 64'(fetch_data), 64'd0);
        @(negedge clk);
        flush       = 1'b0;
        fetch_valid = 1'b0;
        #1;
        check("flush no fill", 64'(mem_cs), 64'd0);
        check("flush no miss", 64'(miss_count), 64'(exp_miss));
        @(negedge clk);
        do_fetch(15'h0010, 2, 0, -1, "post flush0");
        do_fetch(15'h0050, 2, 0, -1, "post flush1");
        do_fetch(15'h0090, 2, 0, -1, "post flush2");
        do_fetch(15'h00D0, 2, 0, -1, "post flush3");
        exp_miss += 4;
        check("miss_count post flush", 64'(miss_count), 64'(exp_miss));

        // Flush in the fill completion cycle leaves the line invalid.
        do_fetch(15'h0200, 4, 0, 1, "flush fill");
        exp_miss += 2;
        check("miss_count flush fill", 64'(miss_count), 64'(exp_miss));
        do_fetch(15'h0204, 0, 0, -1, "flush fill hit");

        // Reset in the middle of a fill.
        fetch_valid = 1'b1;
        fetch_addr  = 15'h0300;
        rom_rdy     = 1'b0;
        @(negedge clk);
        #1;
        check("midfill req up", 64'(mem_addr_valid), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst async mem_cs", 64'(mem_cs), 64'd0);
        check("rst async addr_valid", 64'(mem_addr_valid), 64'd0);
        check("rst async miss_count", 64'(miss_count), 64'd0);
        fetch_valid = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        rom_rdy = 1'b1;
        exp_miss = 0;
        @(negedge clk);
        do_fetch(15'h0300, 2, 0, -1, "after rst");
        do_fetch(15'h0200, 2, 0, -1, "after rst other");
        exp_miss += 2;
        check("miss_count after rst", 64'(miss_count), 64'(exp_miss));
        fetch_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
